// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings and helpers for the timer sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_OVF  = 2'b01,
        ST_UDF  = 2'b10,
        ST_BOTH = 2'b11
    } status_e;

    localparam int TCR_LOAD   = 7;
    localparam int TCR_DIR    = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    // Terminal prescaler count for a clock-select code: 2^(cks+1)-1, code clamped to cks_max.
    function automatic logic [4:0] div_last(input logic [1:0] cks, input int cks_max);
        int c;
        c = (int'(cks) > cks_max) ? cks_max : int'(cks);
        return 5'((2 << c) - 1);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by 2^(cks+1) while run_i is high; clears on !run_i or a cks change.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int CKS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    input  logic [1:0] cks_i,
    output logic       tick_o
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]       last, last_q;
    logic             hit, tick_q;

    always_comb begin
        last      = div_last(cks_i, CKS_MAX);
        hit       = run_i && (last == last_q) && (div_cnt_q == DIV_W'(last));
        div_cnt_d = (!run_i || (last != last_q) || hit) ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            last_q    <= 5'd1;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            last_q    <= last;
            tick_q    <= hit;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: TCR decode, load/run/halt sequencing, prescaled ticks and TSR flag reload strobes.
// Optional one-shot halt on ovf/udf is enabled by defining TIMER_ONE_SHOT_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int CKS_MAX = 3
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] reg_TCR,
    input  logic [7:0] reg_TDR,
    input  logic       tsr_wr,
    input  logic [1:0] tsr_wr_mask,
    input  logic       tmr_ovf,
    input  logic       tmr_udf,
    output logic       cnt_tick,
    output logic       cnt_load,
    output logic [7:0] cnt_load_val,
    output logic       cnt_dir,
    output logic [1:0] status,
    output logic [1:0] ctrl_state
);

`ifdef TIMER_ONE_SHOT_EN
    localparam bit ONE_SHOT = 1'b1;
`else
    localparam bit ONE_SHOT = 1'b0;
`endif

    state_e     state_q, state_d;
    status_e    status_q;
    logic [7:0] val_q;
    logic       dir_q, flag_q;
    logic       load, en, run, os_edge;
    logic       unused_tcr;

    assign load       = reg_TCR[TCR_LOAD];
    assign en         = reg_TCR[TCR_EN];
    assign os_edge    = ONE_SHOT && (tmr_ovf || tmr_udf) && !flag_q;
    assign unused_tcr = ^{reg_TCR[6], reg_TCR[3:2]};

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = S_LOAD;
        else if (!en)
            state_d = S_IDLE;
        else if (state_q == S_RUN)
            state_d = os_edge ? S_HALT : S_RUN;
        else if (state_q != S_HALT)
            state_d = S_RUN;
    end

    // Count only while staying in RUN, so leaving RUN never coincides with a tick.
    assign run = (state_q == S_RUN) && (state_d == S_RUN);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            status_q <= ST_NONE;
            val_q    <= 8'h00;
            dir_q    <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_e'({tsr_wr & tsr_wr_mask[1], tsr_wr & tsr_wr_mask[0]});
            val_q    <= (state_d == S_LOAD) ? reg_TDR : val_q;
            dir_q    <= reg_TCR[TCR_DIR];
            flag_q   <= tmr_ovf | tmr_udf;
        end
    end

    timer_prescaler #(
        .DIV_W  (DIV_W),
        .CKS_MAX(CKS_MAX)
    ) u_prescaler (
        .clk   (PCLK),
        .rst   (PRESET),
        .run_i (run),
        .cks_i (reg_TCR[TCR_CKS_HI:TCR_CKS_LO]),
        .tick_o(cnt_tick)
    );

    assign cnt_load     = (state_q == S_LOAD);
    assign cnt_load_val = val_q;
    assign cnt_dir      = dir_q;
    assign status       = status_q;
    assign ctrl_state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed vector table plus hand sequences for prescaler, load, reset and one-shot.
module tb_timer_ctrl;

    typedef struct {
        logic       rst;
        logic [7:0] tcr;
        logic [7:0] tdr;
        logic       wr;
        logic [1:0] mask;
        logic       e_tick;
        logic       e_load;
        logic [7:0] e_val;
        logic       e_dir;
        logic [1:0] e_status;
        logic [1:0] e_state;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tcr = 8'h00;
    logic [7:0] tdr = 8'h00;
    logic       wr = 1'b0;
    logic [1:0] mask = 2'b00;
    logic       ovf = 1'b0;
    logic       udf = 1'b0;
    logic       tick, load, dir;
    logic [7:0] val;
    logic [1:0] status, state;

    int checks = 0;
    int errors = 0;

    vec_t vecs[24];

    timer_ctrl dut (
        .PCLK        (clk),
        .PRESET      (rst),
        .reg_TCR     (tcr),
        .reg_TDR     (tdr),
        .tsr_wr      (wr),
        .tsr_wr_mask (mask),
        .tmr_ovf     (ovf),
        .tmr_udf     (udf),
        .cnt_tick    (tick),
        .cnt_load    (load),
        .cnt_load_val(val),
        .cnt_dir     (dir),
        .status      (status),
        .ctrl_state  (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tcr = 8'h00;
        ovf = 1'b0;
        udf = 1'b0;
        wr  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Steps n cycles; tick must stay low until exactly the n-th.
    task automatic expect_tick_after(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            step();
            chk(name, {7'd0, tick}, {7'd0, i == n});
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] c, input logic [7:0] d,
                                input logic w, input logic [1:0] m, input logic et,
                                input logic el, input logic [7:0] ev, input logic ed,
                                input logic [1:0] es, input logic [1:0] est);
        vec_t v;
        v.rst = r; v.tcr = c; v.tdr = d; v.wr = w; v.mask = m;
        v.e_tick = et; v.e_load = el; v.e_val = ev; v.e_dir = ed;
        v.e_status = es; v.e_state = est;
        return v;
    endfunction

    initial begin
        //          rst tcr    tdr    wr mask   tick load val    dir status state
        vecs[0]  = mk(1, 8'h10, 8'hA5, 0, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'd0);
        vecs[1]  = mk(1, 8'h80, 8'hA5, 0, 2'b00, 0, 0, 8'h00, 0, 2'b00, 2'd0);
        vecs[2]  = mk(0, 8'h80, 8'hA5, 0, 2'b00, 0, 1, 8'hA5, 0, 2'b00, 2'd1);
        vecs[3]  = mk(0, 8'h80, 8'hA5, 0, 2'b00, 0, 1, 8'hA5, 0, 2'b00, 2'd1);
        vecs[4]  = mk(0, 8'h80, 8'hA5, 0, 2'b00, 0, 1, 8'hA5, 0, 2'b00, 2'd1);
        vecs[5]  = mk(0, 8'h10, 8'hA5, 0, 2'b00, 0, 0, 8'hA5, 0, 2'b00, 2'd2);
        vecs[6]  = mk(0, 8'h10, 8'hA5, 0, 2'b00, 0, 0, 8'hA5, 0, 2'b00, 2'd2);
        vecs[7]  = mk(0, 8'h10, 8'hA5, 0, 2'b00, 1, 0, 8'hA5, 0, 2'b00, 2'd2);
        vecs[8]  = mk(0, 8'h10, 8'hA5, 1, 2'b10, 0, 0, 8'hA5, 0, 2'b10, 2'd2);
        vecs[9]  = mk(0, 8'h10, 8'hA5, 1, 2'b11, 1, 0, 8'hA5, 0, 2'b11, 2'd2);
        vecs[10] = mk(0, 8'h30, 8'hA5, 0, 2'b00, 0, 0, 8'hA5, 1, 2'b00, 2'd2);
        vecs[11] = mk(0, 8'h30, 8'hA5, 0, 2'b00, 1, 0, 8'hA5, 1, 2'b00, 2'd2);
        vecs[12] = mk(0, 8'h10, 8'hA5, 1, 2'b01, 0, 0, 8'hA5, 0, 2'b01, 2'd2);
        vecs[13] = mk(0, 8'h10, 8'hA5, 0, 2'b00, 1, 0, 8'hA5, 0, 2'b00, 2'd2);
        vecs[14] = mk(0, 8'h10, 8'hA5, 0, 2'b00, 0, 0, 8'hA5, 0, 2'b00, 2'd2);
        vecs[15] = mk(0, 8'h00, 8'hA5, 0, 2'b00, 0, 0, 8'hA5, 0, 2'b00, 2'd0);
        vecs[16] = mk(0, 8'h00, 8'hA5, 1, 2'b11, 0, 0, 8'hA5, 0, 2'b11, 2'd0);
        vecs[17] = mk(0, 8'h91, 8'h5A, 0, 2'b00, 0, 1, 8'h5A, 0, 2'b00, 2'd1);
        vecs[18] = mk(0, 8'h11, 8'h5A, 0, 2'b00, 0, 0, 8'h5A, 0, 2'b00, 2'd2);
        vecs[19] = mk(0, 8'h11, 8'h5A, 0, 2'b11, 0, 0, 8'h5A, 0, 2'b00, 2'd2);
        vecs[20] = mk(0, 8'h11, 8'h5A, 0, 2'b00, 0, 0, 8'h5A, 0, 2'b00, 2'd2);
        vecs[21] = mk(0, 8'h11, 8'h5A, 0, 2'b00, 0, 0, 8'h5A, 0, 2'b00, 2'd2);
        vecs[22] = mk(0, 8'h11, 8'h5A, 0, 2'b00, 1, 0, 8'h5A, 0, 2'b00, 2'd2);
        vecs[23] = mk(0, 8'h11, 8'h5A, 0, 2'b00, 0, 0, 8'h5A, 0, 2'b00, 2'd2);

        for (int i = 0; i < 24; i++) begin
            rst = vecs[i].rst; tcr = vecs[i].tcr; tdr = vecs[i].tdr;
            wr = vecs[i].wr; mask = vecs[i].mask;
            step();
            chk($sformatf("v%0d tick", i), {7'd0, tick}, {7'd0, vecs[i].e_tick});
            chk($sformatf("v%0d load", i), {7'd0, load}, {7'd0, vecs[i].e_load});
            chk($sformatf("v%0d val", i), val, vecs[i].e_val);
            chk($sformatf("v%0d dir", i), {7'd0, dir}, {7'd0, vecs[i].e_dir});
            chk($sformatf("v%0d status", i), {6'd0, status}, {6'd0, vecs[i].e_status});
            chk($sformatf("v%0d state", i), {6'd0, state}, {6'd0, vecs[i].e_state});
        end
        wr = 1'b0;

        // cks=2 period 8, then cks change at the would-be tick edge suppresses it.
        do_reset();
        tcr = 8'h12;
        step();
        chk("cks2 enter", {6'd0, state}, 8'd2);
        expect_tick_after(8, "cks2 first");
        expect_tick_after(8, "cks2 second");
        for (int i = 0; i < 7; i++) begin
            step();
            chk("cks2 pre-switch", {7'd0, tick}, 8'd0);
        end
        tcr = 8'h10;
        step();
        chk("cks switch no tick", {7'd0, tick}, 8'd0);
        expect_tick_after(2, "cks0 first");
        expect_tick_after(2, "cks0 second");

        // Load and enable together in RUN at a tick edge.
        do_reset();
        tcr = 8'h10;
        step();
        step();
        tcr = 8'h90;
        step();
        chk("load+en state", {6'd0, state}, 8'd1);
        chk("load+en tick", {7'd0, tick}, 8'd0);
        chk("load+en load", {7'd0, load}, 8'd1);
        tcr = 8'h10;
        step();
        chk("reload run", {6'd0, state}, 8'd2);
        chk("reload load", {7'd0, load}, 8'd0);
        expect_tick_after(2, "reload tick");

        // Reset at a tick edge in RUN.
        do_reset();
        tcr = 8'h10;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst mid-run tick", {7'd0, tick}, 8'd0);
        chk("rst mid-run state", {6'd0, state}, 8'd0);
        rst = 1'b0;
        step();
        chk("rst release run", {6'd0, state}, 8'd2);

        // Overflow behaviour: flag high at entry is ignored, a later rising edge may halt.
        do_reset();
        ovf = 1'b1;
        tcr = 8'h10;
        step();
        chk("ovf entry state", {6'd0, state}, 8'd2);
        expect_tick_after(2, "ovf high at entry");
        ovf = 1'b0;
        step();
        chk("ovf low tick", {7'd0, tick}, 8'd0);
        ovf = 1'b1;
        step();
`ifdef TIMER_ONE_SHOT_EN
        chk("oneshot halt state", {6'd0, state}, 8'd3);
        chk("oneshot halt tick", {7'd0, tick}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("halt no tick", {7'd0, tick}, 8'd0);
            chk("halt state", {6'd0, state}, 8'd3);
        end
        tcr = 8'h90;
        step();
        chk("halt to load", {6'd0, state}, 8'd1);
        tcr = 8'h10;
        step();
        chk("load to run", {6'd0, state}, 8'd2);
        expect_tick_after(2, "after halt tick");
`else
        chk("freerun state", {6'd0, state}, 8'd2);
        chk("freerun tick", {7'd0, tick}, 8'd1);
        expect_tick_after(2, "freerun next");
        udf = 1'b1;
        expect_tick_after(2, "freerun udf");
        chk("freerun never halt", {6'd0, state}, 8'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
